// File: rtl/icache_resp_pkg.sv
// Shared constants, state and read-type encodings for the instruction cache responder.
package icache_resp_pkg;

    localparam int ICACHE_TAG_WD = 20;
    localparam int ICACHE_IDX_WD = 8;
    localparam int ICACHE_OFF_WD = 4;
    localparam int SETS          = 256;
    localparam int LINE_WORDS    = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        MISS   = 2'd2,
        REFILL = 2'd3
    } state_e;

    localparam logic RD_WORD = 1'b0;
    localparam logic RD_LINE = 1'b1;

    // Uncached reads fetch only the requested word; cached reads fetch the whole line.
    function automatic logic [31:0] bus_addr(input logic                     uc,
                                             input logic [ICACHE_TAG_WD-1:0] tag,
                                             input logic [ICACHE_IDX_WD-1:0] idx,
                                             input logic [1:0]               word);
        return uc ? {tag, idx, word, 2'b00} : {tag, idx, 4'b0000};
    endfunction

endpackage

// File: rtl/icache_tagv_ram.sv
// Tag + valid storage: synchronous write, asynchronous read, valid bits cleared on reset.
module icache_tagv_ram
    import icache_resp_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ICACHE_IDX_WD-1:0] raddr,
    output logic [ICACHE_TAG_WD-1:0] rtag,
    output logic                     rvalid,
    input  logic                     we,
    input  logic [ICACHE_IDX_WD-1:0] waddr,
    input  logic [ICACHE_TAG_WD-1:0] wtag
);

    logic [SETS-1:0]          valid_q;
    logic [SETS-1:0]          valid_d;
    logic [ICACHE_TAG_WD-1:0] tag_q [SETS];

    always_comb begin
        valid_d = valid_q;
        if (we) valid_d[waddr] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) valid_q <= '0;
        else       valid_q <= valid_d;
    end

    // Tags need no reset: they are only trusted when the matching valid bit is set.
    always_ff @(posedge clk) begin
        if (we) tag_q[waddr] <= wtag;
    end

    assign rtag   = tag_q[raddr];
    assign rvalid = valid_q[raddr];

endmodule

// File: rtl/icache_resp.sv
// Direct-mapped instruction cache responder (256 sets x 16-byte lines) with a single-miss read bus.
// Optional hit/miss counters are enabled by defining ICACHE_PERF_CNT_EN.
module icache_resp
    import icache_resp_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     inst_cache_valid,
    input  logic                     inst_cache_uncache,
    input  logic [ICACHE_TAG_WD-1:0] inst_cache_tag,
    input  logic [ICACHE_IDX_WD-1:0] inst_cache_index,
    input  logic [ICACHE_OFF_WD-1:0] inst_cache_offset,
    output logic                     inst_cache_addr_ok,
    output logic                     inst_cache_data_ok,
    output logic [31:0]              inst_cache_rdata,
    output logic                     rd_req,
    output logic                     rd_type,
    output logic [31:0]              rd_addr,
    input  logic                     rd_rdy,
    input  logic                     ret_valid,
    input  logic                     ret_last,
    input  logic [31:0]              ret_data
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]              perf_hit,
    output logic [31:0]              perf_miss
`endif
);

    state_e                          state_q, state_d;
    logic                            req_uc_q, req_uc_d;
    logic [ICACHE_TAG_WD-1:0]        req_tag_q, req_tag_d;
    logic [ICACHE_IDX_WD-1:0]        req_idx_q, req_idx_d;
    logic [1:0]                      req_word_q, req_word_d;
    logic [1:0]                      beat_q, beat_d;
    logic [LINE_WORDS-1:0][31:0]     line_buf_q, line_buf_d;
    logic [LINE_WORDS-1:0][31:0]     line_wr;
    logic [LINE_WORDS-1:0][31:0]     data_ram [SETS];

    logic [ICACHE_TAG_WD-1:0]        tag_rd;
    logic                            tag_valid;
    logic                            lookup_hit;
    logic                            refill_done;
    logic                            line_we;
    logic                            accept;
    logic                            offset_unused;

    assign offset_unused = ^inst_cache_offset[1:0];

    icache_tagv_ram u_tagv (
        .clk    (clk),
        .reset  (reset),
        .raddr  (req_idx_q),
        .rtag   (tag_rd),
        .rvalid (tag_valid),
        .we     (line_we),
        .waddr  (req_idx_q),
        .wtag   (req_tag_q)
    );

    assign lookup_hit  = (state_q == LOOKUP) && !req_uc_q && tag_valid && (tag_rd == req_tag_q);
    assign refill_done = (state_q == REFILL) && ret_valid && (req_uc_q || ret_last);
    assign line_we     = refill_done && !req_uc_q;

    // addr_ok is forced low while reset is held even though the state already reads IDLE.
    assign inst_cache_addr_ok = !reset && ((state_q == IDLE) || lookup_hit);
    assign accept             = inst_cache_valid && inst_cache_addr_ok;

    always_comb begin
        line_wr         = line_buf_q;
        line_wr[beat_q] = ret_data;
    end

    always_comb begin
        state_d    = state_q;
        req_uc_d   = req_uc_q;
        req_tag_d  = req_tag_q;
        req_idx_d  = req_idx_q;
        req_word_d = req_word_q;
        beat_d     = beat_q;
        line_buf_d = line_buf_q;

        if (accept) begin
            req_uc_d   = inst_cache_uncache;
            req_tag_d  = inst_cache_tag;
            req_idx_d  = inst_cache_index;
            req_word_d = inst_cache_offset[3:2];
        end

        case (state_q)
            IDLE: begin
                if (accept) state_d = LOOKUP;
            end
            LOOKUP: begin
                if (lookup_hit) state_d = accept ? LOOKUP : IDLE;
                else            state_d = MISS;
            end
            MISS: begin
                beat_d = 2'd0;
                if (rd_rdy) state_d = REFILL;
            end
            REFILL: begin
                if (ret_valid) begin
                    line_buf_d = line_wr;
                    beat_d     = beat_q + 2'd1;
                    if (refill_done) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            req_uc_q   <= 1'b0;
            req_tag_q  <= '0;
            req_idx_q  <= '0;
            req_word_q <= 2'd0;
            beat_q     <= 2'd0;
            line_buf_q <= '0;
        end else begin
            state_q    <= state_d;
            req_uc_q   <= req_uc_d;
            req_tag_q  <= req_tag_d;
            req_idx_q  <= req_idx_d;
            req_word_q <= req_word_d;
            beat_q     <= beat_d;
            line_buf_q <= line_buf_d;
        end
    end

    // The whole line, including the beat arriving now, lands in one write.
    always_ff @(posedge clk) begin
        if (line_we) data_ram[req_idx_q] <= line_wr;
    end

    always_comb begin
        inst_cache_data_ok = lookup_hit || refill_done;
        inst_cache_rdata   = 32'd0;
        if (lookup_hit)       inst_cache_rdata = data_ram[req_idx_q][req_word_q];
        else if (refill_done) inst_cache_rdata = req_uc_q ? ret_data : line_wr[req_word_q];
    end

    always_comb begin
        rd_req  = (state_q == MISS);
        rd_type = RD_WORD;
        rd_addr = 32'd0;
        if (state_q == MISS) begin
            rd_type = req_uc_q ? RD_WORD : RD_LINE;
            rd_addr = bus_addr(req_uc_q, req_tag_q, req_idx_q, req_word_q);
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] perf_hit_q, perf_hit_d;
    logic [31:0] perf_miss_q, perf_miss_d;

    always_comb begin
        perf_hit_d  = perf_hit_q + 32'(lookup_hit);
        perf_miss_d = perf_miss_q + 32'((state_q == LOOKUP) && !req_uc_q && !lookup_hit);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_hit_q  <= 32'd0;
            perf_miss_q <= 32'd0;
        end else begin
            perf_hit_q  <= perf_hit_d;
            perf_miss_q <= perf_miss_d;
        end
    end

    assign perf_hit  = perf_hit_q;
    assign perf_miss = perf_miss_q;
`endif

endmodule

// File: tb/tb_icache_resp.sv
// Testbench for icache_resp: directed vector table, hand-written corner sequences,
// then randomized requests checked against a set-level cache model and a fixed memory image.
module tb_icache_resp;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_cache_valid;
    logic        inst_cache_uncache;
    logic [19:0] inst_cache_tag;
    logic [7:0]  inst_cache_index;
    logic [3:0]  inst_cache_offset;
    logic        inst_cache_addr_ok;
    logic        inst_cache_data_ok;
    logic [31:0] inst_cache_rdata;
    logic        rd_req;
    logic        rd_type;
    logic [31:0] rd_addr;
    logic        rd_rdy;
    logic        ret_valid;
    logic        ret_last;
    logic [31:0] ret_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    icache_resp dut (
        .clk                (clk),
        .reset              (reset),
        .inst_cache_valid   (inst_cache_valid),
        .inst_cache_uncache (inst_cache_uncache),
        .inst_cache_tag     (inst_cache_tag),
        .inst_cache_index   (inst_cache_index),
        .inst_cache_offset  (inst_cache_offset),
        .inst_cache_addr_ok (inst_cache_addr_ok),
        .inst_cache_data_ok (inst_cache_data_ok),
        .inst_cache_rdata   (inst_cache_rdata),
        .rd_req             (rd_req),
        .rd_type            (rd_type),
        .rd_addr            (rd_addr),
        .rd_rdy             (rd_rdy),
        .ret_valid          (ret_valid),
        .ret_last           (ret_last),
        .ret_data           (ret_data)
    );

    // Backing memory image: fixed contents for the directed lines, a scramble elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h1FC0_0018)     return 32'h0000_DEAD;
        if (a[31:4] == 28'h1FC0000) return 32'h11 * (32'(a[3:2]) + 32'd1);
        return {a[15:0] ^ 16'hC3A5, a[31:16]} ^ 32'h0F0F_1234;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic clearInputs();
        inst_cache_valid   = 1'b0;
        inst_cache_uncache = 1'b0;
        inst_cache_tag     = '0;
        inst_cache_index   = '0;
        inst_cache_offset  = '0;
        rd_rdy             = 1'b0;
        ret_valid          = 1'b0;
        ret_last           = 1'b0;
        ret_data           = '0;
    endtask

    task automatic resetDut();
        clearInputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Issues one request and plays the bridge; entered and left just after a rising edge.
    task automatic applyStimulus(input  logic        uc,
                                 input  logic [19:0] tag,
                                 input  logic [7:0]  idx,
                                 input  logic [3:0]  off,
                                 input  int          rdy_delay,
                                 input  bit          gaps,
                                 output bit          got,
                                 output logic [31:0] data,
                                 output int          lat,
                                 output bit          saw_req,
                                 output logic        rtype,
                                 output logic [31:0] raddr,
                                 output bit          stable,
                                 output bit          aok_low);
        bit          accepted;
        bit          acc_now;
        bit          hs;
        int          phase;
        int          k;
        int          waitc;
        int          nb;
        logic [31:0] base;

        got = 0; data = '0; lat = 0; saw_req = 0; rtype = 1'b0; raddr = '0;
        stable = 1; aok_low = 1; accepted = 0;

        inst_cache_valid   = 1'b1;
        inst_cache_uncache = uc;
        inst_cache_tag     = tag;
        inst_cache_index   = idx;
        inst_cache_offset  = off;
        for (int c = 0; c < 20 && !accepted; c++) begin
            @(negedge clk);
            acc_now = inst_cache_addr_ok;
            @(posedge clk);
            #1;
            if (acc_now) accepted = 1;
        end
        inst_cache_valid = 1'b0;
        checkOutput("request_accepted", 32'(accepted), 32'd1);
        if (!accepted) return;

        phase = 0; k = 0; waitc = 0;
        nb    = uc ? 1 : 4;
        base  = uc ? {tag, idx, off[3:2], 2'b00} : {tag, idx, 4'h0};
        for (int c = 0; c < 200 && !got; c++) begin
            rd_rdy = (phase == 0) && saw_req && (waitc >= rdy_delay);
            if (phase == 1 && k < nb && !(gaps && $urandom_range(0, 3) == 0)) begin
                ret_valid = 1'b1;
                ret_data  = mem_word(base + 32'(k * 4));
                ret_last  = (k == nb - 1);
            end else begin
                ret_valid = 1'b0;
                ret_data  = $urandom;
                ret_last  = 1'b0;
            end
            @(negedge clk);
            if (inst_cache_data_ok) begin
                got  = 1;
                data = inst_cache_rdata;
                lat  = c + 1;
            end
            if (rd_req) begin
                if (!saw_req) begin
                    saw_req = 1;
                    rtype   = rd_type;
                    raddr   = rd_addr;
                end else if (rd_type !== rtype || rd_addr !== raddr) begin
                    stable = 0;
                end
            end
            if ((rd_req || phase == 1) && inst_cache_addr_ok) aok_low = 0;
            hs = rd_req && rd_rdy;
            @(posedge clk);
            #1;
            if (phase == 0) begin
                if (hs)           phase = 1;
                else if (saw_req) waitc++;
            end else if (ret_valid) begin
                k++;
            end
        end
        rd_rdy    = 1'b0;
        ret_valid = 1'b0;
        ret_last  = 1'b0;
        ret_data  = '0;
        checkOutput("data_ok_seen", 32'(got), 32'd1);
    endtask

    typedef struct {
        logic        uc;
        logic [19:0] tag;
        logic [7:0]  idx;
        logic [3:0]  off;
        int          delay;
        bit          exp_miss;
        logic        exp_type;
        logic [31:0] exp_addr;
        logic [31:0] exp_data;
    } vec_t;

    vec_t        vecs [8];
    bit          got, saw_req, stable, aok_low;
    logic [31:0] data, raddr;
    logic        rtype;
    int          lat;
    bit          m_valid [256];
    logic [19:0] m_tag   [256];
    logic [19:0] tag_pool [4];

    initial begin : watchdog
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    initial begin
        vecs[0] = '{1'b0, 20'h1FC00, 8'h00, 4'h4, 0, 1'b1, 1'b1, 32'h1FC0_0000, 32'h0000_0022};
        vecs[1] = '{1'b0, 20'h1FC00, 8'h00, 4'hC, 0, 1'b0, 1'b0, 32'h0,         32'h0000_0044};
        vecs[2] = '{1'b1, 20'h1FC00, 8'h01, 4'h8, 0, 1'b1, 1'b0, 32'h1FC0_0018, 32'h0000_DEAD};
        vecs[3] = '{1'b0, 20'h1FC00, 8'h01, 4'h8, 5, 1'b1, 1'b1, 32'h1FC0_0010, 32'h0000_DEAD};
        vecs[4] = '{1'b0, 20'h00ABC, 8'h01, 4'h0, 1, 1'b1, 1'b1, 32'h00AB_C010, mem_word(32'h00AB_C010)};
        vecs[5] = '{1'b0, 20'h1FC00, 8'h01, 4'h8, 0, 1'b1, 1'b1, 32'h1FC0_0010, 32'h0000_DEAD};
        vecs[6] = '{1'b0, 20'hFFFFF, 8'hFF, 4'hC, 2, 1'b1, 1'b1, 32'hFFFF_FFF0, mem_word(32'hFFFF_FFFC)};
        vecs[7] = '{1'b0, 20'hFFFFF, 8'hFF, 4'h0, 0, 1'b0, 1'b0, 32'h0,         mem_word(32'hFFFF_FFF0)};
        tag_pool = '{20'h00001, 20'h1FC00, 20'h12345, 20'hABCDE};

        clearInputs();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_addr_ok", 32'(inst_cache_addr_ok), 32'd0);
        checkOutput("reset_data_ok", 32'(inst_cache_data_ok), 32'd0);
        checkOutput("reset_rdata",   inst_cache_rdata,        32'd0);
        checkOutput("reset_rd_req",  32'(rd_req),             32'd0);
        checkOutput("reset_rd_type", 32'(rd_type),            32'd0);
        checkOutput("reset_rd_addr", rd_addr,                 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("idle_addr_ok", 32'(inst_cache_addr_ok), 32'd1);
        @(posedge clk);
        #1;

        $display("[TB] directed vector table");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].uc, vecs[i].tag, vecs[i].idx, vecs[i].off, vecs[i].delay, 1'b0,
                          got, data, lat, saw_req, rtype, raddr, stable, aok_low);
            checkOutput($sformatf("vec%0d_miss", i), 32'(saw_req), 32'(vecs[i].exp_miss));
            if (vecs[i].exp_miss) begin
                checkOutput($sformatf("vec%0d_rd_type", i), 32'(rtype), 32'(vecs[i].exp_type));
                checkOutput($sformatf("vec%0d_rd_addr", i), raddr, vecs[i].exp_addr);
                checkOutput($sformatf("vec%0d_rd_stable", i), 32'(stable), 32'd1);
                checkOutput($sformatf("vec%0d_addr_ok_low", i), 32'(aok_low), 32'd0 + 32'd1);
            end else begin
                checkOutput($sformatf("vec%0d_hit_latency", i), 32'(lat), 32'd1);
            end
            checkOutput($sformatf("vec%0d_rdata", i), data, vecs[i].exp_data);
        end

        $display("[TB] back-to-back hits on line 0x1FC00000");
        inst_cache_valid   = 1'b1;
        inst_cache_uncache = 1'b0;
        inst_cache_tag     = 20'h1FC00;
        inst_cache_index   = 8'h00;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) inst_cache_offset = 4'(i * 4);
            else       inst_cache_valid  = 1'b0;
            @(negedge clk);
            if (i < 4) checkOutput($sformatf("b2b%0d_addr_ok", i), 32'(inst_cache_addr_ok), 32'd1);
            if (i > 0) begin
                checkOutput($sformatf("b2b%0d_data_ok", i), 32'(inst_cache_data_ok), 32'd1);
                checkOutput($sformatf("b2b%0d_rdata", i), inst_cache_rdata, 32'h11 * 32'(i));
            end
            checkOutput($sformatf("b2b%0d_rd_req", i), 32'(rd_req), 32'd0);
            @(posedge clk);
            #1;
        end

        $display("[TB] reset asserted mid-refill");
        inst_cache_valid   = 1'b1;
        inst_cache_uncache = 1'b0;
        inst_cache_tag     = 20'h00777;
        inst_cache_index   = 8'h22;
        inst_cache_offset  = 4'h0;
        @(negedge clk);
        checkOutput("rst_seq_accept", 32'(inst_cache_addr_ok), 32'd1);
        @(posedge clk);
        #1;
        inst_cache_valid = 1'b0;
        @(posedge clk);
        #1;
        rd_rdy = 1'b1;
        @(negedge clk);
        checkOutput("rst_seq_rd_req", 32'(rd_req), 32'd1);
        @(posedge clk);
        #1;
        rd_rdy = 1'b0;
        for (int b = 0; b < 2; b++) begin
            ret_valid = 1'b1;
            ret_last  = 1'b0;
            ret_data  = mem_word(32'h0077_7220 + 32'(b * 4));
            @(posedge clk);
            #1;
        end
        ret_valid = 1'b0;
        @(negedge clk);
        checkOutput("rst_seq_refill_addr_ok", 32'(inst_cache_addr_ok), 32'd0);
        reset = 1'b1;
        #1;
        checkOutput("rst_seq_addr_ok", 32'(inst_cache_addr_ok), 32'd0);
        checkOutput("rst_seq_data_ok", 32'(inst_cache_data_ok), 32'd0);
        checkOutput("rst_seq_rdata",   inst_cache_rdata,        32'd0);
        checkOutput("rst_seq_rd_req0", 32'(rd_req),             32'd0);
        checkOutput("rst_seq_rd_addr", rd_addr,                 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        applyStimulus(1'b0, 20'h00777, 8'h22, 4'h4, 0, 1'b0,
                      got, data, lat, saw_req, rtype, raddr, stable, aok_low);
        checkOutput("rst_seq_rerequest_miss", 32'(saw_req), 32'd1);
        checkOutput("rst_seq_rerequest_rdata", data, mem_word(32'h0077_7224));

        $display("[TB] randomized requests against reference model");
        resetDut();
        for (int s = 0; s < 256; s++) m_valid[s] = 0;
        for (int n = 0; n < 250; n++) begin
            logic        uc;
            logic [19:0] tag;
            logic [7:0]  idx;
            logic [3:0]  off;
            int          r;
            bit          exp_miss;
            logic [31:0] word_addr;

            uc  = ($urandom_range(0, 4) == 0);
            tag = tag_pool[$urandom_range(0, 3)];
            r   = $urandom_range(0, 7);
            idx = (r == 7) ? 8'hFF : 8'(r);
            off = 4'($urandom_range(0, 15));
            word_addr = {tag, idx, off[3:2], 2'b00};
            exp_miss  = uc || !m_valid[idx] || (m_tag[idx] != tag);

            applyStimulus(uc, tag, idx, off, $urandom_range(0, 3), 1'b1,
                          got, data, lat, saw_req, rtype, raddr, stable, aok_low);
            checkOutput($sformatf("rnd%0d_miss", n), 32'(saw_req), 32'(exp_miss));
            checkOutput($sformatf("rnd%0d_rdata", n), data, mem_word(word_addr));
            if (exp_miss) begin
                checkOutput($sformatf("rnd%0d_rd_type", n), 32'(rtype), 32'(!uc));
                checkOutput($sformatf("rnd%0d_rd_addr", n), raddr,
                            uc ? word_addr : {tag, idx, 4'h0});
            end else begin
                checkOutput($sformatf("rnd%0d_hit_latency", n), 32'(lat), 32'd1);
            end
            if (!uc) begin
                m_valid[idx] = 1;
                m_tag[idx]   = tag;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
